// File: rtl/apu_mixer_dac.sv
// apu_mixer_dac: frame-based CHANNELS-voice mixer with per-channel and master gain,
// saturating scale to OUT_W bits, and a 1-bit PWM or first-order delta-sigma DAC.
module apu_mixer_dac #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 4,
    parameter int GAIN_W   = 4,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 6,
    parameter int MODE     = 0
) (
    input  logic                         apu_clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*SAMPLE_W-1:0] ch_data,
    input  logic [CHANNELS-1:0]          ch_mute,
    input  logic                         cfg_we,
    input  logic [$clog2(CHANNELS):0]    cfg_addr,
    input  logic [GAIN_W-1:0]            cfg_data,
    output logic [OUT_W-1:0]             sample_out,
    output logic                         sample_valid,
    output logic                         clip,
    output logic                         audio_out
);

    localparam int IDX_W  = $clog2(CHANNELS);
    localparam int ACC_W  = IDX_W + SAMPLE_W + GAIN_W;
    localparam int PROD_W = ACC_W + GAIN_W;
    localparam logic [IDX_W:0]   MASTER_ADDR = (IDX_W + 1)'(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        SNAP,
        ACC,
        SCALE
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic [CHANNELS*SAMPLE_W-1:0]    snap_q, snap_d;
    logic [CHANNELS-1:0]             mute_snap_q, mute_snap_d;
    logic [OUT_W-1:0]                sample_q, sample_d;
    logic                            clip_q, clip_d;
    logic                            valid_q, valid_d;
    logic [CHANNELS-1:0][GAIN_W-1:0] gain_q;
    logic [GAIN_W-1:0]               master_q;
    logic                            audio_q;

    logic [SAMPLE_W-1:0] cur_sample;
    logic [ACC_W-1:0]    term;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   scaled;

    // Gain register file: writes land next cycle, so a same-cycle read sees the old gain.
    always_ff @(posedge apu_clk) begin
        if (!rst_n) begin
            gain_q   <= '1;
            master_q <= '1;
        end else if (cfg_we) begin
            if (cfg_addr < MASTER_ADDR) begin
                gain_q[cfg_addr[IDX_W-1:0]] <= cfg_data;
            end else if (cfg_addr == MASTER_ADDR) begin
                master_q <= cfg_data;
            end
        end
    end

    // Mix FSM state and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge apu_clk) begin
        if (!rst_n) begin
            state_q     <= SNAP;
            idx_q       <= '0;
            acc_q       <= '0;
            snap_q      <= '0;
            mute_snap_q <= '0;
            sample_q    <= '0;
            clip_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            snap_q      <= snap_d;
            mute_snap_q <= mute_snap_d;
            sample_q    <= sample_d;
            clip_q      <= clip_d;
            valid_q     <= valid_d;
        end
    end

    // Next-state: snapshot inputs, accumulate one channel per cycle, then scale and saturate.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        snap_d      = snap_q;
        mute_snap_d = mute_snap_q;
        sample_d    = sample_q;
        clip_d      = clip_q;
        valid_d     = 1'b0;

        cur_sample = snap_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
        term       = ACC_W'(cur_sample) * ACC_W'(gain_q[idx_q]);
        prod       = PROD_W'(acc_q) * PROD_W'(master_q);
        scaled     = prod >> SHIFT;

        unique case (state_q)
            SNAP: begin
                snap_d      = ch_data;
                mute_snap_d = ch_mute;
                acc_d       = '0;
                idx_d       = '0;
                state_d     = ACC;
            end
            ACC: begin
                acc_d = acc_q + (mute_snap_q[idx_q] ? '0 : term);
                if (idx_q == LAST_IDX) begin
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SCALE: begin
                if ((scaled >> OUT_W) != '0) begin
                    sample_d = '1;
                    clip_d   = 1'b1;
                end else begin
                    sample_d = scaled[OUT_W-1:0];
                    clip_d   = 1'b0;
                end
                valid_d = 1'b1;
                state_d = SNAP;
            end
            default: state_d = SNAP;
        endcase
    end

    generate
        if (MODE == 0) begin : g_pwm
            logic [OUT_W-1:0] cnt_q;
            logic [OUT_W-1:0] duty_q;
            logic [OUT_W-1:0] duty_eff;

            // The duty loaded at counter 0 already governs that first compare of the period.
            assign duty_eff = (cnt_q == '0) ? sample_q : duty_q;

            // PWM: free-running counter, duty latched once per period for glitch-free pulses.
            always_ff @(posedge apu_clk) begin
                if (!rst_n) begin
                    cnt_q   <= '0;
                    duty_q  <= '0;
                    audio_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == '0) begin
                        duty_q <= sample_q;
                    end
                    audio_q <= (cnt_q < duty_eff);
                end
            end
        end else begin : g_dsm
            logic [OUT_W-1:0] ds_q;
            logic [OUT_W:0]   ds_sum;

            assign ds_sum = {1'b0, ds_q} + {1'b0, sample_q};

            // First-order delta-sigma: the accumulator carry is the 1-bit output.
            always_ff @(posedge apu_clk) begin
                if (!rst_n) begin
                    ds_q    <= '0;
                    audio_q <= 1'b0;
                end else begin
                    ds_q    <= ds_sum[OUT_W-1:0];
                    audio_q <= ds_sum[OUT_W];
                end
            end
        end
    endgenerate

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign clip         = clip_q;
    assign audio_out    = audio_q;

endmodule

// File: tb/tb_apu_mixer_dac.sv
// Directed bench for apu_mixer_dac: default PWM instance (a), SHIFT=4 instance (b),
// delta-sigma instance (c). All share clock, reset and voice inputs; each has its own cfg_we.
module tb_apu_mixer_dac;

    logic        apu_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] ch_data;
    logic [3:0]  ch_mute;
    logic        cfg_we_a, cfg_we_b, cfg_we_c;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_data;

    logic [7:0] a_sample, b_sample, c_sample;
    logic       a_valid, b_valid, c_valid;
    logic       a_clip, b_clip, c_clip;
    logic       a_audio, b_audio, c_audio;

    int checks = 0;
    int errors = 0;

    always #5 apu_clk = ~apu_clk;

    apu_mixer_dac #(.CHANNELS(4), .SAMPLE_W(4), .GAIN_W(4), .OUT_W(8), .SHIFT(6), .MODE(0)) u_a (
        .apu_clk(apu_clk), .rst_n(rst_n), .ch_data(ch_data), .ch_mute(ch_mute),
        .cfg_we(cfg_we_a), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sample_out(a_sample), .sample_valid(a_valid), .clip(a_clip), .audio_out(a_audio));

    apu_mixer_dac #(.CHANNELS(4), .SAMPLE_W(4), .GAIN_W(4), .OUT_W(8), .SHIFT(4), .MODE(0)) u_b (
        .apu_clk(apu_clk), .rst_n(rst_n), .ch_data(ch_data), .ch_mute(ch_mute),
        .cfg_we(cfg_we_b), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sample_out(b_sample), .sample_valid(b_valid), .clip(b_clip), .audio_out(b_audio));

    apu_mixer_dac #(.CHANNELS(4), .SAMPLE_W(4), .GAIN_W(4), .OUT_W(8), .SHIFT(6), .MODE(1)) u_c (
        .apu_clk(apu_clk), .rst_n(rst_n), .ch_data(ch_data), .ch_mute(ch_mute),
        .cfg_we(cfg_we_c), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sample_out(c_sample), .sample_valid(c_valid), .clip(c_clip), .audio_out(c_audio));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where instance a shows sample_valid; n = cycles taken.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge apu_clk);
            n++;
            if (a_valid) break;
        end
        if (!a_valid) check(tag, 32'(a_valid), 32'd1);
    endtask

    task automatic next_frames(input string tag);
        int n;
        wait_valid(tag, n);
        wait_valid(tag, n);
    endtask

    task automatic cfg_write(input int which, input int addr, input int data);
        @(negedge apu_clk);
        cfg_addr = 3'(addr);
        cfg_data = 4'(data);
        cfg_we_a = (which == 0);
        cfg_we_b = (which == 1);
        cfg_we_c = (which == 2);
        @(negedge apu_clk);
        cfg_we_a = 1'b0;
        cfg_we_b = 1'b0;
        cfg_we_c = 1'b0;
    endtask

    // Count consecutive negedges on which instance a's audio_out equals v.
    task automatic count_run(input logic v, output int n);
        n = 0;
        while (a_audio === v && n < 600) begin
            n++;
            @(negedge apu_clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, hi, lo, ones, toggles, first;
        logic prev;

        ch_data  = 16'h0000;
        ch_mute  = 4'b0000;
        cfg_we_a = 1'b0;
        cfg_we_b = 1'b0;
        cfg_we_c = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;

        // Reset state
        repeat (3) @(negedge apu_clk);
        check("rst_sample", 32'(a_sample), 32'd0);
        check("rst_valid",  32'(a_valid),  32'd0);
        check("rst_clip",   32'(a_clip),   32'd0);
        check("rst_audio",  32'(a_audio),  32'd0);
        check("rst_audio_ds", 32'(c_audio), 32'd0);
        check("rst_clip_b", 32'(b_clip),   32'd0);

        // ch0=15 only; instance c gets ch3 gain 10, master 10 for a later 128 mix
        ch_data = 16'h000F;
        rst_n   = 1'b1;
        cfg_write(2, 3, 10);
        cfg_write(2, 4, 10);
        next_frames("to_ch0");
        check("ch0_sample",   32'(a_sample), 32'd52);   // 225*15=3375>>6
        check("ch0_clip",     32'(a_clip),   32'd0);
        check("ch0_shift4",   32'(b_sample), 32'd210);  // 3375>>4
        check("ch0_ds",       32'(c_sample), 32'd35);   // 225*10=2250>>6
        check("ch0_valid_c",  32'(c_valid),  32'd1);
        wait_valid("period", n);
        check("valid_period", 32'(n), 32'd6);

        // PWM with steady duty 52, then sample_out changes mid-period
        repeat (300) @(negedge apu_clk);
        first = 0;
        for (int k = 0; k < 600; k++) begin
            prev = a_audio;
            @(negedge apu_clk);
            if (!prev && a_audio) begin
                first = 1;
                break;
            end
        end
        check("pwm_rise_seen", 32'(first), 32'd1);
        count_run(1'b1, hi);
        check("pwm_hi_52", 32'(hi), 32'd52);
        count_run(1'b0, lo);
        check("pwm_lo_204", 32'(lo), 32'd204);
        ch_data = 16'hFFFF;
        count_run(1'b1, hi);
        check("pwm_hi_midupd", 32'(hi), 32'd52);
        count_run(1'b0, lo);
        check("pwm_lo_midupd", 32'(lo), 32'd204);
        count_run(1'b1, hi);
        check("pwm_hi_210", 32'(hi), 32'd210);

        // All channels 15
        next_frames("to_all15");
        check("all15_sample", 32'(a_sample), 32'd210);  // 900*15=13500>>6
        check("all15_clip",   32'(a_clip),   32'd0);
        check("sat_sample",   32'(b_sample), 32'd255);  // 13500>>4=843
        check("sat_clip",     32'(b_clip),   32'd1);
        check("ds_sample",    32'(c_sample), 32'd128);  // 825*10=8250>>6

        // Delta-sigma density at 128: strict alternation
        ones    = 0;
        toggles = 0;
        prev    = c_audio;
        for (int k = 0; k < 256; k++) begin
            @(negedge apu_clk);
            if (c_audio) ones++;
            if (c_audio !== prev) toggles++;
            prev = c_audio;
        end
        check("ds_ones",    32'(ones),    32'd128);
        check("ds_toggles", 32'(toggles), 32'd256);

        // Mute ch0
        ch_mute = 4'b0001;
        next_frames("to_mute");
        check("mute_sample", 32'(a_sample), 32'd158);   // 675*15=10125>>6
        ch_mute = 4'b0000;

        // Input change during ACC does not tear the frame
        wait_valid("tear_a", n);
        @(negedge apu_clk);
        ch_data = 16'h0000;
        wait_valid("tear_b", n);
        check("snap_hold", 32'(a_sample), 32'd210);
        wait_valid("tear_c", n);
        check("snap_zero", 32'(a_sample), 32'd0);
        ch_data = 16'hFFFF;
        next_frames("tear_d");

        // Gain writes
        cfg_write(0, 0, 0);
        next_frames("to_g0");
        check("gain0_zero", 32'(a_sample), 32'd158);    // 675*15>>6
        cfg_write(0, 4, 7);
        next_frames("to_m7");
        check("master7", 32'(a_sample), 32'd73);        // 675*7=4725>>6
        cfg_write(0, 5, 0);
        next_frames("to_addr5");
        check("addr5_ignored", 32'(a_sample), 32'd73);
        cfg_write(1, 4, 4);
        next_frames("to_m4");
        check("master4_b", 32'(b_sample), 32'd225);     // 900*4=3600>>4
        check("master4_clip", 32'(b_clip), 32'd0);

        // Reset mid-ACC: outputs cleared, next valid only after a full fresh frame
        wait_valid("pre_rst", n);
        @(negedge apu_clk);
        rst_n = 1'b0;
        @(negedge apu_clk);
        check("mrst_sample", 32'(a_sample), 32'd0);
        check("mrst_valid",  32'(a_valid),  32'd0);
        check("mrst_audio",  32'(a_audio),  32'd0);
        check("mrst_ds",     32'(c_sample), 32'd0);
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge apu_clk);
            if (a_valid && first == 0) first = k;
            if (first != 0) break;
        end
        check("mrst_first_valid", 32'(first), 32'd6);
        check("mrst_gain_reset", 32'(a_sample), 32'd210);
        check("mrst_clip_b",     32'(b_clip),   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
